// File: rtl/ipsl_pcie_cfg_apb_seq.sv
// APB initiator: one PCIe config command -> ID/NUM/DATA/CTRL writes, completion poll, data fetch, W1C clear, one response.
// Latency: accept at T, rsp_valid at T+1+2*N transfers with zero-wait slave; each extra poll +2, each ACCESS wait +1.
// Backpressure: cmd_ready only in IDLE; APB ACCESS held until p_rdy. Option macro: IPSL_PCIE_CFG_SEQ_TIMEOUT_EN (poll limit).
module ipsl_pcie_cfg_apb_seq #(
    parameter int unsigned POLL_MAX = 1023
) (
    input  logic        pclk_div2,
    input  logic        apb_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic        cmd_type,
    input  logic [3:0]  cmd_fbe,
    input  logic [7:0]  cmd_tag,
    input  logic [15:0] cmd_req_id,
    input  logic [15:0] cmd_des_id,
    input  logic [9:0]  cmd_reg_num,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [2:0]  rsp_status,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        p_sel,
    output logic        p_ce,
    output logic        p_we,
    output logic [7:0]  p_addr,
    output logic [31:0] p_wdata,
    output logic [3:0]  p_strb,
    input  logic        p_rdy,
    input  logic [31:0] p_rdata
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_ID, S_WR_NUM, S_WR_DATA, S_WR_CTRL, S_POLL, S_RD_DATA, S_CLR, S_RESP
    } state_t;

    typedef struct packed {
        logic        wr;
        logic        typ;
        logic [3:0]  fbe;
        logic [7:0]  tag;
        logic [15:0] req_id;
        logic [15:0] des_id;
        logic [9:0]  reg_num;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } apb_req_t;

    // A zero poll limit would never let a poll complete under the timeout option.
    if (POLL_MAX == 0) begin : g_poll_max_chk
        $error("POLL_MAX must be at least 1");
    end

    // Register image for each step of the sequence; reads carry no data or strobes.
    function automatic apb_req_t req_of(input state_t s, input cmd_t c);
        apb_req_t r;
        r = '0;
        case (s)
            S_WR_ID:   r = '{we: 1'b1, addr: 8'h04, wdata: {c.des_id, c.req_id}, strb: 4'hF};
            S_WR_NUM:  r = '{we: 1'b1, addr: 8'h08, wdata: {7'd0, 1'b1, 14'd0, c.reg_num}, strb: 4'hF};
            S_WR_DATA: r = '{we: 1'b1, addr: 8'h0C, wdata: c.wdata, strb: 4'hF};
            S_WR_CTRL: r = '{we: 1'b1, addr: 8'h00,
                             wdata: {7'd0, 1'b1, 8'd0, c.tag, 2'b00, c.fbe, c.typ, c.wr}, strb: 4'hF};
            S_POLL:    r = '{we: 1'b0, addr: 8'h00, wdata: 32'd0, strb: 4'h0};
            S_RD_DATA: r = '{we: 1'b0, addr: 8'h10, wdata: 32'd0, strb: 4'h0};
            S_CLR:     r = '{we: 1'b1, addr: 8'h00, wdata: 32'h000F_0000, strb: 4'b1100};
            default:   r = '0;
        endcase
        return r;
    endfunction

    state_t   state_q, state_d;
    cmd_t     cmd_q, cmd_d;
    apb_req_t req_q, req_d;
    logic     p_sel_q, p_sel_d, p_ce_q, p_ce_d;
    logic     cmd_ready_q, cmd_ready_d;
    logic     rsp_valid_q, rsp_valid_d;
    logic [2:0]  sts_q, sts_d, rsp_status_q, rsp_status_d;
    logic [31:0] rd_q, rd_d, rsp_rdata_q, rsp_rdata_d;
    logic     load;
`ifdef IPSL_PCIE_CFG_SEQ_TIMEOUT_EN
    localparam int unsigned PCW = $clog2(POLL_MAX + 1);
    logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
    logic     to_q, to_d, rsp_timeout_q, rsp_timeout_d;
`endif

    // Next-state: sequence stepping, APB phase control, result capture and response load.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        req_d        = req_q;
        p_sel_d      = p_sel_q;
        p_ce_d       = p_ce_q;
        sts_d        = sts_q;
        rd_d         = rd_q;
        rsp_valid_d  = 1'b0;
        rsp_status_d = rsp_status_q;
        rsp_rdata_d  = rsp_rdata_q;
        load         = 1'b0;
`ifdef IPSL_PCIE_CFG_SEQ_TIMEOUT_EN
        poll_cnt_d    = poll_cnt_q;
        to_d          = to_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_d.wr      = cmd_wr;
                    cmd_d.typ     = cmd_type;
                    cmd_d.fbe     = cmd_fbe;
                    cmd_d.tag     = cmd_tag;
                    cmd_d.req_id  = cmd_req_id;
                    cmd_d.des_id  = cmd_des_id;
                    cmd_d.reg_num = cmd_reg_num;
                    cmd_d.wdata   = cmd_wdata;
                    sts_d         = 3'd0;
                    rd_d          = 32'd0;
`ifdef IPSL_PCIE_CFG_SEQ_TIMEOUT_EN
                    poll_cnt_d    = '0;
                    to_d          = 1'b0;
`endif
                    state_d       = S_WR_ID;
                    load          = 1'b1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: begin
                if (!p_ce_q) begin
                    p_ce_d = 1'b1;
                end else if (p_rdy) begin
                    load = 1'b1;
                    case (state_q)
                        S_WR_ID:   state_d = S_WR_NUM;
                        S_WR_NUM:  state_d = cmd_q.wr ? S_WR_DATA : S_WR_CTRL;
                        S_WR_DATA: state_d = S_WR_CTRL;
                        S_WR_CTRL: state_d = S_POLL;
                        S_POLL: begin
                            if (p_rdata[16]) begin
                                sts_d   = p_rdata[19:17];
                                state_d = cmd_q.wr ? S_CLR : S_RD_DATA;
                            end else begin
                                state_d = S_POLL;
`ifdef IPSL_PCIE_CFG_SEQ_TIMEOUT_EN
                                if (poll_cnt_q == PCW'(POLL_MAX - 1)) begin
                                    to_d    = 1'b1;
                                    sts_d   = 3'd0;
                                    rd_d    = 32'd0;
                                    state_d = S_CLR;
                                end else begin
                                    poll_cnt_d = poll_cnt_q + 1'b1;
                                end
`endif
                            end
                        end
                        S_RD_DATA: begin
                            rd_d    = p_rdata;
                            state_d = S_CLR;
                        end
                        default:   state_d = S_RESP;
                    endcase
                end
            end
        endcase
        if (load) begin
            if (state_d == S_RESP) begin
                p_sel_d      = 1'b0;
                p_ce_d       = 1'b0;
                rsp_valid_d  = 1'b1;
                rsp_status_d = sts_q;
                rsp_rdata_d  = rd_q;
`ifdef IPSL_PCIE_CFG_SEQ_TIMEOUT_EN
                rsp_timeout_d = to_q;
`endif
            end else begin
                p_sel_d = 1'b1;
                p_ce_d  = 1'b0;
                req_d   = req_of(state_d, cmd_d);
            end
        end
        cmd_ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs; reset aborts any transfer immediately.
    always_ff @(posedge pclk_div2 or negedge apb_rst_n) begin
        if (!apb_rst_n) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            req_q        <= '0;
            p_sel_q      <= 1'b0;
            p_ce_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            sts_q        <= 3'd0;
            rd_q         <= 32'd0;
            rsp_status_q <= 3'd0;
            rsp_rdata_q  <= 32'd0;
`ifdef IPSL_PCIE_CFG_SEQ_TIMEOUT_EN
            poll_cnt_q    <= '0;
            to_q          <= 1'b0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            req_q        <= req_d;
            p_sel_q      <= p_sel_d;
            p_ce_q       <= p_ce_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            sts_q        <= sts_d;
            rd_q         <= rd_d;
            rsp_status_q <= rsp_status_d;
            rsp_rdata_q  <= rsp_rdata_d;
`ifdef IPSL_PCIE_CFG_SEQ_TIMEOUT_EN
            poll_cnt_q    <= poll_cnt_d;
            to_q          <= to_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_status_q;
    assign rsp_rdata  = rsp_rdata_q;
`ifdef IPSL_PCIE_CFG_SEQ_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif
    assign p_sel   = p_sel_q;
    assign p_ce    = p_ce_q;
    assign p_we    = req_q.we;
    assign p_addr  = req_q.addr;
    assign p_wdata = req_q.wdata;
    assign p_strb  = req_q.strb;

endmodule

// File: doc/ipsl_pcie_cfg_apb_seq.md
# ipsl_pcie_cfg_apb_seq

APB initiator that turns a single PCIe configuration-access command into the full register sequence on the `ipsl_pcie_cfg_ctrl` APB register block. It loads IDs, register number and data, then fires `tx_en`, polls for completion, fetches read data and clears the W1C status. It returns one response per command. It sits between the host-side command logic and the cfg-ctrl APB slave, on the `pclk_div2` domain.

## Interface
- `POLL_MAX`, default 1023: maximum number of completion-poll reads before timeout; only used with the timeout feature.
- `pclk_div2`  in  1  clock; one clock, all logic on its rising edge.
- `apb_rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_wr`  in  1  1 = config write TLP (fmt=1), 0 = config read (fmt=0).
- `cmd_type`  in  1  0 = Type0, 1 = Type1.
- `cmd_fbe`  in  4  first byte enables.
- `cmd_tag`  in  8  TLP tag.
- `cmd_req_id`  in  16  requester ID.
- `cmd_des_id`  in  16  destination (completer) ID.
- `cmd_reg_num`  in  10  DW register number.
- `cmd_wdata`  in  32  write payload; ignored for reads.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_status`  out  3  completion status, from reg0[19:17].
- `rsp_rdata`  out  32  completion data for reads; 0 for writes.
- `rsp_timeout`  out  1  poll limit exceeded; valid with `rsp_valid`.
- `p_sel`, `p_ce`, `p_we`  out  1 each  APB select / enable / write.
- `p_addr`  out  8  APB byte address.
- `p_wdata`  out  32  APB write data.
- `p_strb`  out  4  byte strobes.
- `p_rdy`  in  1  APB ready.
- `p_rdata`  in  32  APB read data; valid only while `p_rdy`=1.

## Operation
- All outputs are registered. Reset value is 0 for every output except `cmd_ready`, which resets to 1.
- Command fields are latched on accept (`cmd_valid & cmd_ready`). Inputs are ignored until the next IDLE.
- APB transfer format:
  - SETUP phase: 1 cycle with `p_sel`=1, `p_ce`=0.
  - ACCESS phase: `p_sel`=1, `p_ce`=1, held until `p_rdy`=1.
  - Address, data, strobe and `p_we` are stable across both phases.
  - The next SETUP may follow immediately. Otherwise `p_sel`=`p_ce`=0.
- Reads drive `p_we`=0 and `p_strb`=0. Read data is captured only in the cycle where `p_ce & p_rdy`.
- State sequence:
  - IDLE.
  - WR_ID: addr 0x04, data {des_id, req_id}, strb F.
  - WR_NUM: addr 0x08, data bit24=1 (cfg_ctrl_en), [9:0]=reg_num, all other bits 0, strb F.
  - WR_DATA: addr 0x0C, data = cmd_wdata, strb F. Write commands only.
  - WR_CTRL: addr 0x00, data bit24=1, [15:8]=tag, [5:2]=fbe, bit1=type, bit0=cmd_wr, [23:16]=0, strb F.
  - POLL: read 0x00.
    - If bit16=0: re-issue POLL.
    - If bit16=1: latch bits[19:17] into the status register.
  - RD_DATA: read 0x10, latch into the rdata register. Read commands only.
  - CLR: addr 0x00, data bit24=0, [19:16]=4'hF, other bits 0, strb 4'b1100. This clears the W1C status and tx_en.
  - RESP: `rsp_valid`=1 for one cycle, then IDLE.
- `rsp_rdata` and `rsp_status` hold their values until the next RESP. `rsp_timeout` is set and held in the same way.
- Async reset at any point returns to IDLE and drops `p_sel`/`p_ce` immediately. No response is issued for the aborted command.

## Timing
- Accept in cycle T; the first SETUP is in T+1.
- A transfer against a zero-wait slave takes 2 cycles.
- Response timing: `rsp_valid` is in cycle T+1+2·N, where N is the number of transfers, if every ACCESS completes in 1 cycle.
- Write command with a single poll: N=6, so `rsp_valid` is at T+13.
- Read command with a single poll: N=6, so `rsp_valid` is at T+13.
- Each extra poll adds 2 cycles. Each extra wait cycle in ACCESS adds 1 cycle.
- `cmd_ready` drops in T+1 and returns in the cycle after RESP.

## Configuration
- `IPSL_PCIE_CFG_SEQ_TIMEOUT_EN` defined:
  - A poll counter increments per POLL read.
  - If bit16 is still 0 after `POLL_MAX` reads, the block goes to CLR with `rsp_timeout`=1, `rsp_status`=0, `rsp_rdata`=0.
  - RD_DATA is skipped.
- Undefined: the block polls indefinitely, and `rsp_timeout` is tied to 0.

## Test plan
- Read command (req_id 0x0100, des_id 0x0200, reg_num 0x004, tag 0x05, fbe F); bench completes the first poll with status 0 and data 0x12345678:
  - APB writes 0x04=0x02000100, 0x08=0x01000004, 0x00=0x0100053C.
  - Then read 0x00, read 0x10, and write 0x00=0x000F0000 with strb C.
  - Response: `rsp_rdata`=0x12345678, `rsp_status`=0, `rsp_valid` at T+13.
- Write command with `cmd_wdata`=0xDEADBEEF: transfer to 0x0C=0xDEADBEEF precedes WR_CTRL, and reg0 write data bit0=1. Response: `rsp_rdata`=0.
- Completion arrives after 3 polls with status 3'b001: 3 POLL reads are issued, `rsp_status`=1, and `rsp_valid` is 4 cycles later than the single-poll case.
- Slave inserts 2 extra ACCESS wait cycles on WR_NUM: address and data stay stable, and the response is delayed by exactly 2 cycles.
- With `IPSL_PCIE_CFG_SEQ_TIMEOUT_EN` and `POLL_MAX`=4, completion never arrives: exactly 4 POLLs, then CLR. Response: `rsp_timeout`=1, `rsp_rdata`=0.
- Assert `apb_rst_n` during POLL: all outputs are 0 and `cmd_ready`=1. A new command after release runs the full sequence normally.
